conv_error_monitor: RTL and testbench

Hardware error-statistics collector that sits downstream of an accurate/approximate convolution pair. It buffers each engine's `pixel_out`/`valid` stream independently and pairs results in arrival order, so the two engines may have different latencies. For every pair it emits the signed error and accumulates sum-of-absolute-error, maximum error and mismatch count over a window of `NUM_SAMPLES` pairs. It replaces manual `$monitor` inspection of accurate-vs-approximate outputs with on-chip measurement.

---
 rtl/conv_error_monitor.sv | 138 +++++++++++++
 tb/tb_conv_error_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/conv_error_monitor.sv
// Pairs accurate/approximate convolution results in arrival order and collects
// per-window error statistics (signed error, SAE, max error, mismatch count).
module conv_error_monitor #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned NUM_SAMPLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*DATA_W-1:0]   acc_in,
    input  logic                  acc_valid,
    input  logic [2*DATA_W-1:0]   apx_in,
    input  logic                  apx_valid,
    output logic                  pair_valid,
    output logic [2*DATA_W:0]     pair_err,
    output logic [31:0]           sum_abs_err,
    output logic [2*DATA_W-1:0]   max_abs_err,
    output logic [15:0]           mismatch_cnt,
    output logic [15:0]           pair_cnt,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned RES_W = 2 * DATA_W;
    localparam int unsigned ERR_W = RES_W + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state, state_nxt;

    logic [RES_W-1:0] acc_mem [FIFO_DEPTH];
    logic [RES_W-1:0] apx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] acc_wr, acc_rd, apx_wr, apx_rd;
    logic [CNT_W-1:0] acc_cnt, apx_cnt;

    logic             run_c, pop_c;
    logic             acc_full_c, apx_full_c;
    logic             acc_push_c, apx_push_c;
    logic             drop_c;
    logic [ERR_W-1:0] err_c;
    logic [RES_W-1:0] abs_err_c;
    logic [32:0]      sum_ext_c;
    logic [31:0]      sum_nxt_c;

    // Datapath: enqueue/pop qualification and error arithmetic on FIFO heads
    always_comb begin
        run_c      = (state == S_RUN) && !start;
        pop_c      = run_c && (acc_cnt != '0) && (apx_cnt != '0);
        acc_full_c = (acc_cnt == CNT_W'(FIFO_DEPTH));
        apx_full_c = (apx_cnt == CNT_W'(FIFO_DEPTH));
        acc_push_c = run_c && acc_valid && (!acc_full_c || pop_c);
        apx_push_c = run_c && apx_valid && (!apx_full_c || pop_c);
        drop_c     = run_c && !pop_c && ((acc_valid && acc_full_c) || (apx_valid && apx_full_c));
        err_c      = {1'b0, acc_mem[acc_rd]} - {1'b0, apx_mem[apx_rd]};
        abs_err_c  = err_c[ERR_W-1] ? RES_W'(ERR_W'(0) - err_c) : RES_W'(err_c);
        sum_ext_c  = {1'b0, sum_abs_err} + 33'(abs_err_c);
        sum_nxt_c  = sum_ext_c[32] ? 32'hFFFF_FFFF : sum_ext_c[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (start)
                    state_nxt = S_RUN;
                else if (pop_c && (pair_cnt == 16'(NUM_SAMPLES - 1)))
                    state_nxt = S_DONE;
            end
            S_DONE: if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FIFO storage has no reset; occupancy is tracked by the pointers/counters
    always_ff @(posedge clk) begin
        if (acc_push_c) acc_mem[acc_wr] <= acc_in;
        if (apx_push_c) apx_mem[apx_wr] <= apx_in;
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            acc_wr  <= '0;
            acc_rd  <= '0;
            acc_cnt <= '0;
            apx_wr  <= '0;
            apx_rd  <= '0;
            apx_cnt <= '0;
        end else begin
            if (acc_push_c) acc_wr <= acc_wr + PTR_W'(1);
            if (apx_push_c) apx_wr <= apx_wr + PTR_W'(1);
            if (pop_c) begin
                acc_rd <= acc_rd + PTR_W'(1);
                apx_rd <= apx_rd + PTR_W'(1);
            end
            if (acc_push_c && !pop_c)      acc_cnt <= acc_cnt + CNT_W'(1);
            else if (!acc_push_c && pop_c) acc_cnt <= acc_cnt - CNT_W'(1);
            if (apx_push_c && !pop_c)      apx_cnt <= apx_cnt + CNT_W'(1);
            else if (!apx_push_c && pop_c) apx_cnt <= apx_cnt - CNT_W'(1);
        end
    end

    // Per-pair result and window statistics
    always_ff @(posedge clk) begin
        if (rst || start) begin
            pair_valid   <= 1'b0;
            pair_err     <= '0;
            sum_abs_err  <= '0;
            max_abs_err  <= '0;
            mismatch_cnt <= '0;
            pair_cnt     <= '0;
            overflow     <= 1'b0;
            done         <= 1'b0;
        end else begin
            pair_valid <= pop_c;
            done       <= (state_nxt == S_DONE);
            if (drop_c) overflow <= 1'b1;
            if (pop_c) begin
                pair_err    <= err_c;
                sum_abs_err <= sum_nxt_c;
                if (abs_err_c > max_abs_err) max_abs_err <= abs_err_c;
                if (err_c != '0) mismatch_cnt <= mismatch_cnt + 16'd1;
                pair_cnt <= pair_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_conv_error_monitor.sv
// Directed bench for conv_error_monitor with hand-computed expectations.
module tb_conv_error_monitor;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] acc_in, apx_in;
    logic        acc_valid, apx_valid;
    logic        pair_valid;
    logic [16:0] pair_err;
    logic [31:0] sum_abs_err;
    logic [15:0] max_abs_err, mismatch_cnt, pair_cnt;
    logic        done, overflow;

    int n_checks = 0;
    int n_errors = 0;

    conv_error_monitor #(.DATA_W(8), .FIFO_DEPTH(4), .NUM_SAMPLES(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .acc_in(acc_in), .acc_valid(acc_valid),
        .apx_in(apx_in), .apx_valid(apx_valid),
        .pair_valid(pair_valid), .pair_err(pair_err),
        .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err),
        .mismatch_cnt(mismatch_cnt), .pair_cnt(pair_cnt),
        .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given valids; outputs sampled 1 time unit after the edge
    task automatic cyc(input logic av, input logic [15:0] a, input logic pv, input logic [15:0] p);
        acc_valid = av; acc_in = a;
        apx_valid = pv; apx_in = p;
        @(posedge clk); #1;
        acc_valid = 1'b0; apx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1'b0, 16'd0, 1'b0, 16'd0);
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".outs"}, {pair_valid, pair_err, sum_abs_err, max_abs_err,
                               mismatch_cnt, pair_cnt, done, overflow} != '0, 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        acc_valid = 1'b0; apx_valid = 1'b0; acc_in = '0; apx_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Valids in IDLE are ignored
        cyc(1'b1, 16'd7, 1'b1, 16'd3);
        cyc(1'b0, 16'd0, 1'b0, 16'd0);
        check("idle_ignore.pv", pair_valid, 0);
        check("idle_ignore.ovf", overflow, 0);

        // Basic pair
        pulse_start();
        cyc(1'b1, 16'd1000, 1'b1, 16'd990);
        check("basic.pv_early", pair_valid, 0);
        cyc(1'b0, 16'd0, 1'b0, 16'd0);
        check("basic.pv", pair_valid, 1);
        check("basic.err", pair_err, 17'd10);
        check("basic.sum", sum_abs_err, 10);
        check("basic.max", max_abs_err, 10);
        check("basic.mis", mismatch_cnt, 1);
        check("basic.cnt", pair_cnt, 1);
        cyc(1'b0, 16'd0, 1'b0, 16'd0);
        check("basic.pv_drop", pair_valid, 0);

        // Skewed arrival and negative error, then an exact match
        pulse_start();
        check("restart.cnt", pair_cnt, 0);
        cyc(1'b0, 16'd0, 1'b1, 16'd20);
        cyc(1'b0, 16'd0, 1'b0, 16'd0);
        cyc(1'b0, 16'd0, 1'b0, 16'd0);
        cyc(1'b1, 16'd5, 1'b0, 16'd0);
        check("skew.pv_early", pair_valid, 0);
        cyc(1'b0, 16'd0, 1'b0, 16'd0);
        check("skew.pv", pair_valid, 1);
        check("skew.err", pair_err, 17'h1FFF1);
        check("skew.max", max_abs_err, 15);
        cyc(1'b1, 16'd300, 1'b1, 16'd300);
        cyc(1'b0, 16'd0, 1'b0, 16'd0);
        check("match.err", pair_err, 0);
        check("match.mis", mismatch_cnt, 1);
        check("match.cnt", pair_cnt, 2);
        check("match.sum", sum_abs_err, 15);

        // FIFO overflow, then drain with four apx zeros
        pulse_start();
        for (int i = 1; i <= 4; i++) cyc(1'b1, 16'(i), 1'b0, 16'd0);
        check("ovf.before", overflow, 0);
        cyc(1'b1, 16'd5, 1'b0, 16'd0);
        check("ovf.set", overflow, 1);
        cyc(1'b0, 16'd0, 1'b1, 16'd0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b0, 16'd0, (i < 4), 16'd0);
            check($sformatf("ovf.pair%0d.pv", i), pair_valid, 1);
            check($sformatf("ovf.pair%0d.err", i), pair_err, 64'(i));
        end
        cyc(1'b0, 16'd0, 1'b0, 16'd0);
        check("ovf.no_fifth", pair_valid, 0);
        check("ovf.sum", sum_abs_err, 10);
        check("ovf.cnt", pair_cnt, 4);
        check("ovf.sticky", overflow, 1);

        // Window completion
        pulse_start();
        check("start.ovf_clr", overflow, 0);
        for (int k = 1; k <= 16; k++) cyc(1'b1, 16'd500, 1'b1, 16'd480);
        check("win.cnt15", pair_cnt, 15);
        check("win.not_done", done, 0);
        cyc(1'b1, 16'd500, 1'b1, 16'd480);
        check("win.done", done, 1);
        check("win.pv16", pair_valid, 1);
        check("win.cnt16", pair_cnt, 16);
        check("win.sum", sum_abs_err, 320);
        check("win.max", max_abs_err, 20);
        check("win.mis", mismatch_cnt, 16);
        cyc(1'b1, 16'd9, 1'b1, 16'd1);
        cyc(1'b0, 16'd0, 1'b0, 16'd0);
        check("win.17th_pv", pair_valid, 0);
        check("win.17th_cnt", pair_cnt, 16);
        check("win.17th_sum", sum_abs_err, 320);
        check("win.hold_done", done, 1);
        check("win.done_no_ovf", overflow, 0);
        pulse_start();
        check_all_zero("win.restart");
        cyc(1'b0, 16'd0, 1'b0, 16'd0);
        check("win.flushed", pair_valid, 0);

        // Extremes
        cyc(1'b1, 16'hFFFF, 1'b1, 16'h0000);
        cyc(1'b0, 16'd0, 1'b0, 16'd0);
        check("ext.pos_err", pair_err, 17'h0FFFF);
        check("ext.max", max_abs_err, 16'hFFFF);
        cyc(1'b1, 16'h0000, 1'b1, 16'hFFFF);
        cyc(1'b0, 16'd0, 1'b0, 16'd0);
        check("ext.neg_err", pair_err, 17'h10001);
        check("ext.sum", sum_abs_err, 131070);
        check("ext.mis", mismatch_cnt, 2);

        // Reset mid-window with samples queued, rst winning over start
        pulse_start();
        for (int k = 0; k < 7; k++) cyc(1'b1, 16'd10, 1'b1, 16'd3);
        cyc(1'b1, 16'd11, 1'b0, 16'd0);
        cyc(1'b1, 16'd12, 1'b0, 16'd0);
        check("rstmid.cnt7", pair_cnt, 7);
        check("rstmid.sum", sum_abs_err, 49);
        rst = 1'b1; start = 1'b1;
        cyc(1'b1, 16'd13, 1'b1, 16'd2);
        rst = 1'b0; start = 1'b0;
        check_all_zero("rstmid");
        cyc(1'b1, 16'd4, 1'b1, 16'd2);
        cyc(1'b1, 16'd4, 1'b1, 16'd2);
        cyc(1'b0, 16'd0, 1'b0, 16'd0);
        check("rstmid.idle_pv", pair_valid, 0);
        check("rstmid.idle_cnt", pair_cnt, 0);
        pulse_start();
        cyc(1'b0, 16'd0, 1'b0, 16'd0);
        check("rstmid.fifo_empty", pair_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
